multi_player_buzzer: RTL

Parametrised N-player quiz buzzer, the successor to the two-player buzzer. It adds a synchronised clocked datapath, host arm/clear control, and tie-break arbitration between simultaneous presses. Players who buzz before the host arms are penalised, and an answer-window timeout limits how long a winner holds the round. It sits between the debounced player push-buttons and the LED/display logic on the board.

---
 rtl/multi_player_buzzer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/multi_player_buzzer.sv
// multi_player_buzzer: N-player quiz buzzer with input synchronisers,
// host arm/clear control, false-start penalties, tie-break arbitration
// and an answer-window timeout. All outputs come straight from flops.
module multi_player_buzzer #(
  parameter int N_PLAYERS     = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int ANSWER_CYCLES = 16,
  parameter int TIE_MODE      = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         arm,
  input  logic                         clear,
  input  logic [N_PLAYERS-1:0]         buzz,
  output logic [N_PLAYERS-1:0]         led,
  output logic [$clog2(N_PLAYERS)-1:0] winner_idx,
  output logic                         winner_valid,
  output logic [N_PLAYERS-1:0]         penalty,
  output logic                         timeout,
  output logic [1:0]                   state
);

  localparam int IW = $clog2(N_PLAYERS);
  localparam int CW = (ANSWER_CYCLES > 1) ? $clog2(ANSWER_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = (ANSWER_CYCLES > 0) ? CW'(ANSWER_CYCLES - 1) : {CW{1'b0}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    LOCKED  = 2'd2,
    TIMEOUT = 2'd3
  } state_t;

  // Winner selection: fixed priority scans upward from 0, round-robin
  // scans upward from the pointer and wraps.
  function automatic logic [IW-1:0] pick_winner(input logic [N_PLAYERS-1:0] req,
                                                input logic [IW-1:0]        ptr);
    logic [IW-1:0] idx;
    logic          found;
    int            j;
    idx   = {IW{1'b0}};
    found = 1'b0;
    for (int k = 0; k < N_PLAYERS; k++) begin
      if (TIE_MODE == 1) begin
        j = (int'(ptr) + k) % N_PLAYERS;
      end else begin
        j = k;
      end
      if (!found && req[j]) begin
        idx   = IW'(j);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return idx;
  endfunction

  logic [SYNC_STAGES-1:0][N_PLAYERS-1:0] sync_r;
  logic [N_PLAYERS-1:0]                  hist_r;
  logic [N_PLAYERS-1:0]                  press_s;
  logic [N_PLAYERS-1:0]                  elig_s;
  logic [IW-1:0]                         win_s;

  state_t               state_r,   state_nxt_s;
  logic [N_PLAYERS-1:0] led_r,     led_nxt_s;
  logic [IW-1:0]        widx_r,    widx_nxt_s;
  logic                 wvalid_r,  wvalid_nxt_s;
  logic [N_PLAYERS-1:0] pen_r,     pen_nxt_s;
  logic                 to_r,      to_nxt_s;
  logic [CW-1:0]        cnt_r,     cnt_nxt_s;
  logic [IW-1:0]        rr_r,      rr_nxt_s;

  // Synchroniser chain plus history flop; index 0 is the newest stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {(SYNC_STAGES*N_PLAYERS){1'b0}};
      hist_r <= {N_PLAYERS{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], buzz};
      hist_r <= sync_r[SYNC_STAGES-1];
    end
  end

  // A press is a synchronised rising edge; levels never arbitrate.
  assign press_s = sync_r[SYNC_STAGES-1] & ~hist_r;
  assign elig_s  = press_s & ~pen_r;
  assign win_s   = pick_winner(elig_s, rr_r);

  // Next-state and next-output logic for the round FSM.
  always_comb begin
    state_nxt_s  = state_r;
    led_nxt_s    = led_r;
    widx_nxt_s   = widx_r;
    wvalid_nxt_s = wvalid_r;
    pen_nxt_s    = pen_r;
    to_nxt_s     = to_r;
    cnt_nxt_s    = cnt_r;
    rr_nxt_s     = rr_r;
    if (clear) begin
      state_nxt_s  = IDLE;
      led_nxt_s    = {N_PLAYERS{1'b0}};
      widx_nxt_s   = {IW{1'b0}};
      wvalid_nxt_s = 1'b0;
      pen_nxt_s    = {N_PLAYERS{1'b0}};
      to_nxt_s     = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          // Any press before the round opens (including with arm) is a false start.
          pen_nxt_s = pen_r | press_s;
          if (arm) begin
            state_nxt_s = ARMED;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        ARMED: begin
          if (|elig_s) begin
            state_nxt_s  = LOCKED;
            led_nxt_s    = {{(N_PLAYERS-1){1'b0}}, 1'b1} << win_s;
            widx_nxt_s   = win_s;
            wvalid_nxt_s = 1'b1;
            cnt_nxt_s    = CNT_LOAD;
            if (win_s == IW'(N_PLAYERS - 1)) begin
              rr_nxt_s = {IW{1'b0}};
            end else begin
              rr_nxt_s = win_s + IW'(1'b1);
            end
          end else begin
            state_nxt_s = ARMED;
          end
        end
        LOCKED: begin
          if (ANSWER_CYCLES == 0) begin
            state_nxt_s = LOCKED;
          end else if (cnt_r == {CW{1'b0}}) begin
            state_nxt_s = TIMEOUT;
            led_nxt_s   = {N_PLAYERS{1'b0}};
            to_nxt_s    = 1'b1;
          end else begin
            cnt_nxt_s = cnt_r - CW'(1'b1);
          end
        end
        TIMEOUT: begin
          state_nxt_s = TIMEOUT;
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      led_r    <= {N_PLAYERS{1'b0}};
      widx_r   <= {IW{1'b0}};
      wvalid_r <= 1'b0;
      pen_r    <= {N_PLAYERS{1'b0}};
      to_r     <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      rr_r     <= {IW{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      led_r    <= led_nxt_s;
      widx_r   <= widx_nxt_s;
      wvalid_r <= wvalid_nxt_s;
      pen_r    <= pen_nxt_s;
      to_r     <= to_nxt_s;
      cnt_r    <= cnt_nxt_s;
      rr_r     <= rr_nxt_s;
    end
  end

  assign led          = led_r;
  assign winner_idx   = widx_r;
  assign winner_valid = wvalid_r;
  assign penalty      = pen_r;
  assign timeout      = to_r;
  assign state        = state_r;

endmodule
